// File: rtl/apb_node_guarded_if.sv
// apb_node_guarded_if: upstream APB port, peripheral fan-out and error-status signals of apb_node_guarded.
interface apb_node_guarded_if #(
   parameter int NB_MASTER      = 10,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int ERR_CNT_WIDTH  = 8
);
   logic [APB_ADDR_WIDTH-1:0]                s_paddr_i;
   logic [APB_DATA_WIDTH-1:0]                s_pwdata_i;
   logic                                     s_pwrite_i, s_psel_i, s_penable_i;
   logic [APB_DATA_WIDTH-1:0]                s_prdata_o;
   logic                                     s_pready_o, s_pslverr_o;
   logic [APB_ADDR_WIDTH-1:0]                m_paddr_o;
   logic [APB_DATA_WIDTH-1:0]                m_pwdata_o;
   logic                                     m_pwrite_o, m_penable_o;
   logic [NB_MASTER-1:0]                     m_psel_o;
   logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] m_prdata_i;
   logic [NB_MASTER-1:0]                     m_pready_i, m_pslverr_i;
   logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i, end_addr_i;
   logic [APB_ADDR_WIDTH-1:0]                err_addr_o;
   logic [1:0]                               err_cause_o;
   logic [ERR_CNT_WIDTH-1:0]                 err_cnt_o;
   logic                                     err_clr_i;
   modport slave (
      input  s_paddr_i, s_pwdata_i, s_pwrite_i, s_psel_i, s_penable_i,
      input  m_prdata_i, m_pready_i, m_pslverr_i, start_addr_i, end_addr_i, err_clr_i,
      output s_prdata_o, s_pready_o, s_pslverr_o,
      output m_paddr_o, m_pwdata_o, m_pwrite_o, m_penable_o, m_psel_o,
      output err_addr_o, err_cause_o, err_cnt_o
   );
   modport master (
      output s_paddr_i, s_pwdata_i, s_pwrite_i, s_psel_i, s_penable_i,
      output m_prdata_i, m_pready_i, m_pslverr_i, start_addr_i, end_addr_i, err_clr_i,
      input  s_prdata_o, s_pready_o, s_pslverr_o,
      input  m_paddr_o, m_pwdata_o, m_pwrite_o, m_penable_o, m_psel_o,
      input  err_addr_o, err_cause_o, err_cnt_o
   );
endinterface

// File: rtl/apb_node_guarded.sv
// apb_node_guarded: APB 1-to-N range decoder with decode-error response and sticky error capture.
// Define APB_NODE_WATCHDOG_EN to add the per-transfer watchdog (ABORT response, cause 10).
module apb_node_guarded #(
   parameter int NB_MASTER      = 10,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256,
   parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA = 32'hBADA_CCE5,
   parameter int ERR_CNT_WIDTH  = 8
) (
   input logic               clk_i,
   input logic               rst_ni,
   apb_node_guarded_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE, ACCESS, DECERR
`ifdef APB_NODE_WATCHDOG_EN
      , ABORT
`endif
   } state_t;
   state_t                    state_q, state_d;
   logic [NB_MASTER-1:0]      match, sel_q, sel_d;
   logic                      hit, setup, err_ev, rdy_mux, err_mux;
   logic [APB_DATA_WIDTH-1:0] rdata_mux;
   logic [1:0]                err_code, err_cause_q;
   logic [APB_ADDR_WIDTH-1:0] err_addr_q;
   logic [ERR_CNT_WIDTH-1:0]  err_cnt_q;
`ifdef APB_NODE_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            wd_exp;
   assign wd_exp   = wd_q == WD_W'(TIMEOUT_CYCLES - 1);
   assign err_code = state_q == ABORT ? 2'b10 : 2'b01;
`else
   assign err_code = 2'b01;
`endif
   assign setup           = bus.s_psel_i & ~bus.s_penable_i;
   assign bus.m_paddr_o   = bus.s_paddr_i;
   assign bus.m_pwdata_o  = bus.s_pwdata_i;
   assign bus.m_pwrite_o  = bus.s_pwrite_i;
   assign bus.err_addr_o  = err_addr_q;
   assign bus.err_cause_o = err_cause_q;
   assign bus.err_cnt_o   = err_cnt_q;
   // first matching range wins, so overlaps resolve to the lowest index
   always_comb begin
      match     = '0;
      hit       = 1'b0;
      rdata_mux = '0;
      rdy_mux   = 1'b0;
      err_mux   = 1'b0;
      for (int i = 0; i < NB_MASTER; i++) begin
         if (!hit && bus.start_addr_i[i] <= bus.s_paddr_i && bus.s_paddr_i <= bus.end_addr_i[i]) begin
            match[i] = 1'b1;
            hit      = 1'b1;
         end
         if (sel_q[i]) begin
            rdata_mux = bus.m_prdata_i[i];
            rdy_mux   = bus.m_pready_i[i];
            err_mux   = bus.m_pslverr_i[i];
         end
      end
   end
   always_comb begin
      state_d         = state_q;
      sel_d           = sel_q;
      err_ev          = 1'b0;
      bus.m_psel_o    = '0;
      bus.m_penable_o = 1'b0;
      bus.s_prdata_o  = '0;
      bus.s_pready_o  = 1'b0;
      bus.s_pslverr_o = 1'b0;
`ifdef APB_NODE_WATCHDOG_EN
      wd_d            = '0;
`endif
      case (state_q)
         IDLE: begin
            bus.m_psel_o = match & {NB_MASTER{bus.s_psel_i}};
            if (setup) begin
               state_d = hit ? ACCESS : DECERR;
               sel_d   = match;
            end
         end
         ACCESS: begin
            bus.m_psel_o    = sel_q;
            bus.m_penable_o = bus.s_penable_i;
            bus.s_prdata_o  = bus.s_psel_i ? rdata_mux : '0;
            bus.s_pready_o  = bus.s_psel_i & rdy_mux;
            bus.s_pslverr_o = bus.s_psel_i & err_mux;
            if (!bus.s_psel_i || rdy_mux) state_d = IDLE;
`ifdef APB_NODE_WATCHDOG_EN
            else if (wd_exp) state_d = ABORT;
            else wd_d = wd_q + WD_W'(1);
`endif
         end
`ifdef APB_NODE_WATCHDOG_EN
         DECERR, ABORT: begin
`else
         DECERR: begin
`endif
            bus.s_prdata_o  = bus.s_psel_i ? ERR_RDATA : '0;
            bus.s_pready_o  = bus.s_psel_i;
            bus.s_pslverr_o = bus.s_psel_i;
            err_ev          = bus.s_psel_i;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         err_addr_q  <= '0;
         err_cause_q <= 2'b00;
         err_cnt_q   <= '0;
`ifdef APB_NODE_WATCHDOG_EN
         wd_q        <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
`ifdef APB_NODE_WATCHDOG_EN
         wd_q    <= wd_d;
`endif
         // a new error beats a simultaneous clear
         if (err_ev && (bus.err_clr_i || err_cause_q == 2'b00)) begin
            err_addr_q  <= bus.s_paddr_i;
            err_cause_q <= err_code;
         end else if (bus.err_clr_i) begin
            err_addr_q  <= '0;
            err_cause_q <= 2'b00;
         end
         if (err_ev) err_cnt_q <= bus.err_clr_i ? ERR_CNT_WIDTH'(1) : err_cnt_q + ERR_CNT_WIDTH'(~&err_cnt_q);
         else if (bus.err_clr_i) err_cnt_q <= '0;
      end
   end
endmodule

// File: tb/tb_apb_node_guarded.sv
// tb_apb_node_guarded: table vectors, random transfers against a range-map model, and multi-cycle corner sequences.
module tb_apb_node_guarded;
   localparam int NB = 4, AW = 32, DW = 32, T = 8, ECW = 8;
   localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;
`ifdef APB_NODE_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   localparam int WMAX = WD_EN ? 10 : 5;
   logic clk = 1'b0, rst_n = 1'b0, late_rdy = 1'b0;
   always #5 clk = ~clk;
   apb_node_guarded_if #(.NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .ERR_CNT_WIDTH(ECW)) bus ();
   apb_node_guarded #(.NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(T),
      .ERR_RDATA(ERR_RDATA), .ERR_CNT_WIDTH(ECW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
   int total = 0, bad = 0;
   logic [31:0] start_a [NB] = '{32'h0000, 32'h1000, 32'h1800, 32'h4000};
   logic [31:0] end_a   [NB] = '{32'h0FFF, 32'h1FFF, 32'h2FFF, 32'h4FFF};
   int          wait_cfg [NB];
   int          acc_cnt [NB];
   logic [31:0] rd_val [NB];
   logic        err_cfg [NB];
   logic [31:0] m_addr = '0;
   logic [1:0]  m_cause = 2'b00;
   int          m_cnt = 0;
   // peripherals: ready after wait_cfg ACCESS cycles; port 0 can be forced ready for the late-ready check
   always_comb begin
      for (int i = 0; i < NB; i++) begin
         bus.start_addr_i[i] = start_a[i];
         bus.end_addr_i[i]   = end_a[i];
         bus.m_prdata_i[i]   = rd_val[i];
         bus.m_pslverr_i[i]  = err_cfg[i];
         bus.m_pready_i[i]   = (bus.m_psel_o[i] && bus.m_penable_o && acc_cnt[i] >= wait_cfg[i]) || (i == 0 && late_rdy);
      end
   end
   always_ff @(posedge clk)
      for (int i = 0; i < NB; i++)
         acc_cnt[i] <= (bus.m_psel_o[i] && bus.m_penable_o && !bus.m_pready_i[i]) ? acc_cnt[i] + 1 : 0;
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask
   function automatic int exp_port(input logic [31:0] a);
      for (int i = 0; i < NB; i++) if (a >= start_a[i] && a <= end_a[i]) return i;
      return -1;
   endfunction
   task automatic model_err(input logic [31:0] a, input logic [1:0] c, input logic clr);
      if (clr || m_cause == 2'b00) begin
         m_addr  = a;
         m_cause = c;
      end
      m_cnt = clr ? 1 : (m_cnt < (1 << ECW) - 1 ? m_cnt + 1 : (1 << ECW) - 1);
   endtask
   task automatic chk_err(input string tag);
      chk({tag, " err_addr"}, bus.err_addr_o, m_addr);
      chk({tag, " err_cause"}, bus.err_cause_o, m_cause);
      chk({tag, " err_cnt"}, bus.err_cnt_o, m_cnt);
   endtask
   // entered and left at posedge+1; consecutive calls give back-to-back transfers
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
         output logic [NB-1:0] ssel, output logic [NB-1:0] asel, output logic [31:0] rd,
         output logic se, output int cyc, output logic pt);
      bus.s_paddr_i = a; bus.s_pwrite_i = w; bus.s_pwdata_i = wd;
      bus.s_psel_i = 1'b1; bus.s_penable_i = 1'b0;
      asel = '0; rd = '0; se = 1'b0; cyc = 1;
      #4;
      ssel = bus.m_psel_o;
      pt = bus.m_paddr_o == a && bus.m_pwrite_o == w && bus.m_pwdata_o == wd;
      @(posedge clk); #1 bus.s_penable_i = 1'b1;
      for (int k = 0; k < 100; k++) begin
         cyc++;
         #4;
         asel |= bus.m_psel_o;
         if (bus.s_pready_o) begin
            rd = bus.s_prdata_o;
            se = bus.s_pslverr_o;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.s_psel_i = 1'b0; bus.s_penable_i = 1'b0;
   endtask
   task automatic apply(input string tag, input logic [31:0] a, input logic w,
         input logic [NB-1:0] esel, input logic [1:0] ecause, input int ecyc);
      logic [NB-1:0] ssel, asel;
      logic [31:0]   rd, erd;
      logic          se, ese, pt;
      int            cyc;
      erd = ERR_RDATA;
      ese = 1'b1;
      if (ecause == 2'b00)
         for (int i = 0; i < NB; i++) if (esel[i]) begin erd = rd_val[i]; ese = err_cfg[i]; end
      xfer(a, w, $urandom, ssel, asel, rd, se, cyc, pt);
      chk({tag, " setup_sel"}, ssel, esel);
      chk({tag, " access_sel"}, asel, esel);
      chk({tag, " passthru"}, pt, 1);
      chk({tag, " cycles"}, cyc, ecyc);
      chk({tag, " rdata"}, rd, erd);
      chk({tag, " slverr"}, se, ese);
      if (ecause != 2'b00) model_err(a, ecause, 1'b0);
      chk_err(tag);
   endtask
   task automatic clr_pulse();
      bus.err_clr_i = 1'b1;
      @(posedge clk); #1 bus.err_clr_i = 1'b0;
      m_addr = '0; m_cause = 2'b00; m_cnt = 0;
      chk_err("clear");
   endtask
   typedef struct {
      logic [31:0]   a;
      logic          w;
      int            wt;
      logic [NB-1:0] sel;
      logic [1:0]    cause;
      int            cyc;
   } vec_t;
   vec_t tbl [9];
   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [31:0]   a;
      logic [NB-1:0] esel;
      logic [1:0]    ec;
      logic          tmo;
      int            p, r, ecyc;
      tbl[0] = '{32'h0000_4010, 1'b0, 2, 4'b1000, 2'b00, 4};
      tbl[1] = '{32'hFFFF_0000, 1'b1, 0, 4'b0000, 2'b01, 2};
      tbl[2] = '{32'h0000_1900, 1'b0, 0, 4'b0010, 2'b00, 2};
      tbl[3] = '{32'h0000_2800, 1'b1, 1, 4'b0100, 2'b00, 3};
      tbl[4] = '{32'h0000_0000, 1'b0, 0, 4'b0001, 2'b00, 2};
      tbl[5] = '{32'h0000_0FFF, 1'b0, 3, 4'b0001, 2'b00, 5};
      tbl[6] = '{32'h0000_3000, 1'b0, 0, 4'b0000, 2'b01, 2};
      tbl[7] = '{32'h0000_4FFF, 1'b1, 0, 4'b1000, 2'b00, 2};
      tbl[8] = '{32'h0000_5000, 1'b0, 1, 4'b0000, 2'b01, 2};
      for (int i = 0; i < NB; i++) begin wait_cfg[i] = 0; rd_val[i] = '0; err_cfg[i] = 1'b0; end
      bus.s_paddr_i = '0; bus.s_pwdata_i = '0; bus.s_pwrite_i = 1'b0;
      bus.s_psel_i = 1'b0; bus.s_penable_i = 1'b0; bus.err_clr_i = 1'b0;
      #2;
      chk("rst m_psel", bus.m_psel_o, 0);
      chk("rst m_penable", bus.m_penable_o, 0);
      chk("rst pready", bus.s_pready_o, 0);
      chk("rst pslverr", bus.s_pslverr_o, 0);
      chk("rst prdata", bus.s_prdata_o, 0);
      chk_err("rst");
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 9; k++) begin
         for (int i = 0; i < NB; i++) begin wait_cfg[i] = tbl[k].wt; rd_val[i] = $urandom; err_cfg[i] = 1'b0; end
         rd_val[3] = 32'h1234_5678;
         apply($sformatf("vec%0d", k), tbl[k].a, tbl[k].w, tbl[k].sel, tbl[k].cause, tbl[k].cyc);
      end
      for (int n = 0; n < 150; n++) begin
         for (int i = 0; i < NB; i++) begin
            wait_cfg[i] = $urandom_range(0, WMAX);
            rd_val[i]   = $urandom;
            err_cfg[i]  = $urandom_range(0, 3) == 0;
         end
         r = $urandom_range(0, 5);
         a = r < NB ? start_a[r] + $urandom_range(0, end_a[r] - start_a[r]) :
             r == NB ? 32'h3000 + $urandom_range(0, 32'hFFF) : $urandom;
         p    = exp_port(a);
         esel = p < 0 ? '0 : NB'(1) << p;
         tmo  = WD_EN && p >= 0 && wait_cfg[p] >= T;
         ec   = p < 0 ? 2'b01 : tmo ? 2'b10 : 2'b00;
         ecyc = p < 0 ? 2 : tmo ? T + 2 : wait_cfg[p] + 2;
         apply($sformatf("rnd%0d", n), a, 1'(($urandom)), esel, ec, ecyc);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int i = 0; i < NB; i++) begin wait_cfg[i] = 1; err_cfg[i] = 1'b0; end
      // upstream drops psel mid-ACCESS: no response, nothing recorded
      wait_cfg[3] = 1000;
      bus.s_paddr_i = 32'h4040; bus.s_pwrite_i = 1'b0; bus.s_psel_i = 1'b1; bus.s_penable_i = 1'b0;
      @(posedge clk); #1 bus.s_penable_i = 1'b1;
      @(posedge clk); #1;
      bus.s_psel_i = 1'b0; bus.s_penable_i = 1'b0;
      #4 chk("abandon pready", bus.s_pready_o, 0);
      @(posedge clk); #1;
      chk_err("abandon");
      wait_cfg[3] = 1;
      apply("after_abandon", 32'h4044, 1'b0, 4'b1000, 2'b00, 3);
`ifdef APB_NODE_WATCHDOG_EN
      clr_pulse();
      wait_cfg[0] = 1000;
      apply("timeout", 32'h0000_0100, 1'b0, 4'b0001, 2'b10, T + 2);
      chk("timeout cause", bus.err_cause_o, 2'b10);
      late_rdy = 1'b1;
      #4 chk("late pready", bus.s_pready_o, 0);
      @(posedge clk); #1 late_rdy = 1'b0;
      chk_err("late");
      wait_cfg[0] = 1;
      apply("after_timeout", 32'h0000_0200, 1'b1, 4'b0001, 2'b00, 3);
`endif
      clr_pulse();
      apply("sat0", 32'h0000_3000, 1'b1, '0, 2'b01, 2);
      for (int n = 1; n < 300; n++) apply($sformatf("sat%0d", n), 32'h5000 + n, 1'b0, '0, 2'b01, 2);
      chk("sat cnt", bus.err_cnt_o, 255);
      chk("sat addr", bus.err_addr_o, 32'h3000);
      // clear in the same cycle as a decode error: the error is kept
      bus.s_paddr_i = 32'h3ABC; bus.s_pwrite_i = 1'b1; bus.s_psel_i = 1'b1; bus.s_penable_i = 1'b0;
      @(posedge clk); #1 bus.s_penable_i = 1'b1; bus.err_clr_i = 1'b1;
      #4;
      chk("clrerr pready", bus.s_pready_o, 1);
      chk("clrerr pslverr", bus.s_pslverr_o, 1);
      @(posedge clk); #1;
      bus.err_clr_i = 1'b0; bus.s_psel_i = 1'b0; bus.s_penable_i = 1'b0;
      model_err(32'h3ABC, 2'b01, 1'b1);
      chk_err("clrerr");
      chk("clrerr cnt", bus.err_cnt_o, 1);
      // asynchronous reset while a peripheral holds off pready
      wait_cfg[3] = 1000;
      bus.s_paddr_i = 32'h4100; bus.s_pwrite_i = 1'b0; bus.s_psel_i = 1'b1; bus.s_penable_i = 1'b0;
      @(posedge clk); #1 bus.s_penable_i = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0; bus.s_psel_i = 1'b0; bus.s_penable_i = 1'b0;
      #1;
      m_addr = '0; m_cause = 2'b00; m_cnt = 0;
      chk("arst m_psel", bus.m_psel_o, 0);
      chk("arst m_penable", bus.m_penable_o, 0);
      chk("arst pready", bus.s_pready_o, 0);
      chk("arst pslverr", bus.s_pslverr_o, 0);
      chk("arst prdata", bus.s_prdata_o, 0);
      chk_err("arst");
      @(posedge clk); #1 rst_n = 1'b1;
      wait_cfg[3] = 1;
      apply("post_rst", 32'h4200, 1'b0, 4'b1000, 2'b00, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
